xbar_burst_arbiter: RTL and testbench
=====================================

# xbar_burst_arbiter

Rotating-priority arbiter with grant locking and bounded burst ownership, sharing one crossbar peripheral port between `NUM_REQ` requesters. It sits between the requesters' matching-request lines and the peripheral port mux, and produces the one-hot select that drives the mux. It keeps a grant stable while the peripheral stalls. It lets the current owner keep the port for up to `MAX_BURST` consecutive accepted transfers before priority rotates. With `MAX_BURST = 1` it behaves as a plain round-robin selector.

## Interface
- `NUM_REQ`, default 3: number of requesters, at least 2.
- `MAX_BURST`, default 4: maximum number of consecutive accepted transfers one requester may take while others are waiting. Must be at least 1.
- `clk_i`  in  1: clock. Single clock domain.
- `rst_i`  in  1: reset. Asynchronous, active-high.
- `req_i`  in  NUM_REQ: request lines. A requester holds its request until it sees its grant together with `ready_i`.
- `ready_i`  in  1: peripheral ready. The peripheral accepts the granted request in any cycle where this is high.
- `gnt_o`  out  NUM_REQ: one-hot grant, or all-zero.
- `gnt_valid_o`  out  1: OR-reduction of `gnt_o`.
- `gnt_idx_o`  out  $clog2(NUM_REQ): index of the granted requester. Reads 0 when there is no grant.
- `xfer_o`  out  1: equals `gnt_valid_o & ready_i`, i.e. the granted request is accepted this cycle.
- `proto_err_o`  out  1: one-cycle pulse. Fires when a locked owner deasserts its request before acceptance.

## Operation
- **Registered state**
  - `last_q`: index of the most recent accepted winner.
  - `cnt_q`: number of consecutive accepted transfers by `last_q`. Width is $clog2(MAX_BURST+1); the count saturates at `MAX_BURST`.
  - `lock_q`: the current grant is locked.
  - `owner_q`: index of the locked owner.
- **Reset values**
  - `last_q = NUM_REQ-1`, `cnt_q = MAX_BURST`, `lock_q = 0`, `owner_q = 0`.
  - All outputs are combinational from state and inputs. With `req_i = 0` during or after reset, every output is 0.
- **Priority pointer `ptr`**
  - `ptr = last_q` if `cnt_q < MAX_BURST`.
  - Otherwise `ptr = (last_q + 1) mod NUM_REQ`. Wrap-around from `NUM_REQ-1` goes to 0.
  - Consequence: after reset, `ptr = 0`.
- **Winner selection, in priority order**
  1. If `lock_q` and `req_i[owner_q]`: the winner is `owner_q`, regardless of the other requests.
  2. Otherwise: the winner is the first set bit of `req_i` found by scanning `ptr`, `ptr+1`, … mod `NUM_REQ`.
  3. If `req_i = 0`: there is no grant.
- **Lock update**
  - The next `lock_q` is `gnt_valid_o & ~ready_i`.
  - The next `owner_q` is the winner, loaded only when the lock is set.
- **Protocol error**
  - Condition: `lock_q` is set and `req_i[owner_q]` is low.
  - Response in the same cycle: pulse `proto_err_o`, ignore the lock, and arbitrate normally.
- **On `xfer_o` (winner `w`)**
  - If `w == last_q`: `cnt_q` becomes `cnt_q + 1`, saturating at `MAX_BURST`.
  - Otherwise: `cnt_q` becomes 1.
  - `last_q` becomes `w`.
  - When no transfer occurs, `last_q` and `cnt_q` hold.
- **Burst fairness**
  - Once `cnt_q` reaches `MAX_BURST`, the owner drops to lowest priority.
  - If the owner is the only requester, it still wins; its count stays saturated.
- **Simultaneous events**
  - A stall cycle (`ready_i` low) never changes `last_q`, `cnt_q` or `ptr`. Stalls do not consume burst budget.
  - New requests arriving while the grant is locked do not pre-empt it.
- **Reset mid-operation**
  - Assertion immediately clears the lock and restores the reset state.
  - Any in-flight locked grant is abandoned.
  - The grant outputs then follow the reset-state arbitration.

## Timing
- Grant latency is zero cycles: `gnt_o` reflects `req_i` in the same cycle. The path from `req_i` to `gnt_o` is purely combinational.
- `ready_i` affects `xfer_o` combinationally. It affects the winner only from the next cycle, through the lock.
- A requester whose grant is held by stalls is served in the first cycle that `ready_i` is high. No bubble is inserted.
- Back-to-back accepted transfers are supported every cycle, including a switch to a different requester.
- Worst-case wait for a continuously requesting requester: `(NUM_REQ-1) × MAX_BURST` accepted transfers, plus stall cycles.

## Test plan
- **Reset, then idle:** assert `rst_i` mid-stream, then apply `req_i = 3'b000` → all outputs 0. With `req_i = 3'b111` and `ready_i = 1` → the first grant goes to index 0.
- **Round robin:** `MAX_BURST = 1`, `req_i = 3'b111`, `ready_i = 1` for 6 cycles → `gnt_idx_o` = 0, 1, 2, 0, 1, 2 and `xfer_o = 1` every cycle.
- **Burst bound:** `MAX_BURST = 4`, `req_i = 3'b011` held, `ready_i = 1` → grant sequence 0, 0, 0, 0, 1, 1, 1, 1, 0.
- **Stall lock:** `req_i = 3'b001` with `ready_i = 0` for 3 cycles while `req_i[2]` rises in cycle 2 → `gnt_o` stays `3'b001` throughout. Raising `ready_i` gives `xfer_o = 1` for index 0 that cycle. `cnt_q` increments by 1 only.
- **Protocol error:** index 1 is locked (granted, `ready_i = 0`); next cycle `req_i = 3'b100` → `proto_err_o = 1` for one cycle and `gnt_o = 3'b100`.
- **Sole requester beyond budget:** `MAX_BURST = 2`, only `req_i[2]` set for 5 transfers → granted every cycle with `cnt_q` saturated at 2. Then `req_i = 3'b101` → index 0 wins next.

Source files
------------

// File: rtl/xbar_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : xbar_burst_arbiter
// Description : Rotating-priority arbiter for one crossbar peripheral port.
//               Holds a grant across peripheral stalls (grant locking) and lets
//               the current owner keep the port for up to MAX_BURST
//               consecutive accepted transfers before priority rotates.
//               The grant path from req_i is purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module xbar_burst_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       ready_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       gnt_valid_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
  output logic                       xfer_o,
  output logic                       proto_err_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [IDX_W-1:0] c_LAST_RST  = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   c_NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] c_MAX_CNT   = CNT_W'(MAX_BURST);

  // Registered arbitration state
  logic [IDX_W-1:0] r_last;   // most recent accepted winner
  logic [CNT_W-1:0] r_cnt;    // consecutive accepted transfers by r_last
  logic             r_lock;   // current grant is held across a stall
  logic [IDX_W-1:0] r_owner;  // requester holding the lock

  logic             w_any;
  logic             w_cnt_sat;
  logic [IDX_W-1:0] w_last_inc;
  logic [IDX_W-1:0] w_ptr;
  logic             w_owner_req;
  logic             w_lock_hit;
  logic [IDX_W-1:0] w_rr_idx;
  logic [IDX_W-1:0] w_win;
  logic [IDX_W-1:0] w_scan [NUM_REQ];

  assign w_any       = |req_i;
  assign w_cnt_sat   = (r_cnt == c_MAX_CNT);
  assign w_last_inc  = (r_last == c_LAST_RST) ? '0 : r_last + IDX_W'(1);
  // Owner keeps top priority until its burst budget is spent.
  assign w_ptr       = w_cnt_sat ? w_last_inc : r_last;
  assign w_owner_req = req_i[r_owner];
  assign w_lock_hit  = r_lock & w_owner_req;

  // Scan order: w_scan[k] = (w_ptr + k) mod NUM_REQ, k = 0 is highest priority.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_scan
    logic [IDX_W:0] w_sum;
    logic [IDX_W:0] w_wrap;
    assign w_sum     = {1'b0, w_ptr} + (IDX_W + 1)'(k);
    assign w_wrap    = w_sum - c_NUM_REQ_W;
    assign w_scan[k] = (w_sum >= c_NUM_REQ_W) ? w_wrap[IDX_W-1:0] : w_sum[IDX_W-1:0];
  end

  // Round-robin pick: walk from lowest to highest priority so the last hit wins.
  always_comb begin
    w_rr_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[w_scan[k]]) begin
        w_rr_idx = w_scan[k];
      end
    end
  end

  // A held lock overrides rotation; a dropped lock falls back to normal arbitration.
  assign w_win = w_lock_hit ? r_owner : w_rr_idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_gnt
    assign gnt_o[i] = w_any & (w_win == IDX_W'(i));
  end

  assign gnt_valid_o = w_any;
  assign gnt_idx_o   = w_any ? w_win : '0;
  assign xfer_o      = w_any & ready_i;
  assign proto_err_o = r_lock & ~w_owner_req;

  // Lock tracking: hold the winner while the peripheral stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lock  <= 1'b0;
      r_owner <= '0;
    end else begin
      r_lock <= w_any & ~ready_i;
      if (w_any & ~ready_i) begin
        r_owner <= w_win;
      end
    end
  end

  // Burst accounting: only accepted transfers move the pointer or the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last <= c_LAST_RST;
      r_cnt  <= c_MAX_CNT;
    end else if (w_any & ready_i) begin
      r_last <= w_win;
      if (w_win == r_last) begin
        r_cnt <= w_cnt_sat ? r_cnt : r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xbar_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_xbar_burst_arbiter
// Description : Scoreboard bench for xbar_burst_arbiter. Three instances
//               (MAX_BURST = 1, 4, 2) are exercised one at a time with
//               directed vectors; a negedge monitor checks every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xbar_burst_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0: MAX_BURST=1, 1: MAX_BURST=4, 2: MAX_BURST=2
  logic [2:0] req  [3];
  logic       rdy  [3];
  logic [2:0] gnt  [3];
  logic       gv   [3];
  logic [1:0] gidx [3];
  logic       xf   [3];
  logic       pe   [3];

  xbar_burst_arbiter #(.NUM_REQ(3), .MAX_BURST(1)) u_rr (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .ready_i(rdy[0]),
    .gnt_o(gnt[0]), .gnt_valid_o(gv[0]), .gnt_idx_o(gidx[0]),
    .xfer_o(xf[0]), .proto_err_o(pe[0]));

  xbar_burst_arbiter #(.NUM_REQ(3), .MAX_BURST(4)) u_b4 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .ready_i(rdy[1]),
    .gnt_o(gnt[1]), .gnt_valid_o(gv[1]), .gnt_idx_o(gidx[1]),
    .xfer_o(xf[1]), .proto_err_o(pe[1]));

  xbar_burst_arbiter #(.NUM_REQ(3), .MAX_BURST(2)) u_b2 (
    .clk_i(clk), .rst_i(rst), .req_i(req[2]), .ready_i(rdy[2]),
    .gnt_o(gnt[2]), .gnt_valid_o(gv[2]), .gnt_idx_o(gidx[2]),
    .xfer_o(xf[2]), .proto_err_o(pe[2]));

  typedef struct packed {
    int unsigned cyc;
    logic [1:0]  inst;
    logic [2:0]  gnt;
    logic [1:0]  idx;
    logic        xfer;
    logic        perr;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] oh2idx(input logic [2:0] oh);
    if (oh[2]) return 2'd2;
    if (oh[1]) return 2'd1;
    return 2'd0;
  endfunction

  // Drive one cycle on one instance (others idle) and record the expected response.
  task automatic apply(input int inst, input logic [2:0] r, input logic rd,
                       input logic [2:0] eg, input logic ex, input logic ep);
    exp_t e;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      req[i] = 3'b000;
      rdy[i] = 1'b0;
    end
    req[inst] = r;
    rdy[inst] = rd;
    if (eg != 3'b000 || ep) begin
      e.cyc  = cyc;
      e.inst = 2'(inst);
      e.gnt  = eg;
      e.idx  = oh2idx(eg);
      e.xfer = ex;
      e.perr = ep;
      sb.push_back(e);
    end
  endtask

  // Monitor: pop and compare whenever an expectation is due; flag stray outputs.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (sb.size() > 0 && sb[0].cyc == cyc && sb[0].inst == 2'(i)) begin
        e = sb.pop_front();
        vectors++;
        if ({gnt[i], gv[i], gidx[i], xf[i], pe[i]} !==
            {e.gnt, |e.gnt, e.idx, e.xfer, e.perr}) begin
          miscompares++;
          $display("FAIL inst%0d cyc%0d: got gnt=%b valid=%b idx=%0d xfer=%b perr=%b, want gnt=%b valid=%b idx=%0d xfer=%b perr=%b",
                   i, cyc, gnt[i], gv[i], gidx[i], xf[i], pe[i],
                   e.gnt, |e.gnt, e.idx, e.xfer, e.perr);
        end
      end else if (gv[i] !== 1'b0 || pe[i] !== 1'b0 || gnt[i] !== 3'b000 ||
                   xf[i] !== 1'b0 || gidx[i] !== 2'd0) begin
        miscompares++;
        $display("FAIL idle inst%0d cyc%0d: got gnt=%b valid=%b idx=%0d xfer=%b perr=%b, want all zero",
                 i, cyc, gnt[i], gv[i], gidx[i], xf[i], pe[i]);
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req[i] = 3'b000;
      rdy[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // MAX_BURST=4: first grant after reset goes to 0, then lock owner 0
    apply(1, 3'b111, 1'b1, 3'b001, 1'b1, 1'b0);
    apply(1, 3'b111, 1'b1, 3'b001, 1'b1, 1'b0);
    apply(1, 3'b001, 1'b0, 3'b001, 1'b0, 1'b0);

    // Reset mid-stream with no requests: lock abandoned, all outputs zero
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) req[i] = 3'b000;
    @(posedge clk);
    #1 rst = 1'b0;

    // Burst bound: 0,0,0,0,1,1,1,1,0
    for (int n = 0; n < 4; n++) apply(1, 3'b011, 1'b1, 3'b001, 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) apply(1, 3'b011, 1'b1, 3'b010, 1'b1, 1'b0);
    apply(1, 3'b011, 1'b1, 3'b001, 1'b1, 1'b0);

    // Stall lock: owner 0 held while req[2] rises; stalls spend no budget
    apply(1, 3'b001, 1'b0, 3'b001, 1'b0, 1'b0);
    apply(1, 3'b101, 1'b0, 3'b001, 1'b0, 1'b0);
    apply(1, 3'b101, 1'b0, 3'b001, 1'b0, 1'b0);
    apply(1, 3'b101, 1'b1, 3'b001, 1'b1, 1'b0);
    apply(1, 3'b101, 1'b1, 3'b001, 1'b1, 1'b0);
    apply(1, 3'b101, 1'b1, 3'b001, 1'b1, 1'b0);
    apply(1, 3'b101, 1'b1, 3'b100, 1'b1, 1'b0);

    // Protocol error: locked owner 1 drops its request
    apply(1, 3'b010, 1'b0, 3'b010, 1'b0, 1'b0);
    apply(1, 3'b100, 1'b0, 3'b100, 1'b0, 1'b1);
    apply(1, 3'b100, 1'b1, 3'b100, 1'b1, 1'b0);
    apply(1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);

    // MAX_BURST=1: plain round robin 0,1,2,0,1,2
    for (int n = 0; n < 2; n++) begin
      apply(0, 3'b111, 1'b1, 3'b001, 1'b1, 1'b0);
      apply(0, 3'b111, 1'b1, 3'b010, 1'b1, 1'b0);
      apply(0, 3'b111, 1'b1, 3'b100, 1'b1, 1'b0);
    end
    apply(0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);

    // MAX_BURST=2: sole requester 2 past its budget, then 0 wins, then back to 2
    for (int n = 0; n < 5; n++) apply(2, 3'b100, 1'b1, 3'b100, 1'b1, 1'b0);
    apply(2, 3'b101, 1'b1, 3'b001, 1'b1, 1'b0);
    apply(2, 3'b101, 1'b1, 3'b001, 1'b1, 1'b0);
    apply(2, 3'b101, 1'b1, 3'b100, 1'b1, 1'b0);
    apply(2, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
